tff_bank_counter: RTL and testbench

//  Parametrised bank of WIDTH T flip-flops with a shared async clear; successor to the single-bit udp_tff.

---
 rtl/tff_bank_counter.sv | 143 ++++++++++++++
 tb/tb_tff_bank_counter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/tff_bank_counter.sv
// tff_bank_counter: a bank of WIDTH T flip-flops sharing an async clear.
// It works as an independent toggle bank, an up/down counter built from
// the T chain, or a parallel-load register. tc and ovf flag terminal-value
// edges for timers and dividers.

// One flip-flop of the bank. The cell only knows "toggle" and "load".
// The bank decides which one applies to each bit.
module tff_bank_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic clr_n,
  input  logic ld_i,
  input  logic ld_val_i,
  input  logic tog_i,
  output logic q_o
);

  // Load overrides toggle. The async clear restores this bit's reset value.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)    q_o <= RST_BIT;
    else if (ld_i) q_o <= ld_val_i;
    else           q_o <= q_o ^ tog_i;
  end

endmodule

module tff_bank_counter #(
  parameter int             WIDTH     = 4,
  parameter bit             SATURATE  = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             sclr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [1:0] M_TOGGLE = 2'b00;
  localparam logic [1:0] M_UP     = 2'b01;
  localparam logic [1:0] M_DOWN   = 2'b10;
  localparam logic [1:0] M_LOAD   = 2'b11;

  logic [WIDTH-1:0] up_tog, dn_tog;
  logic [WIDTH-1:0] tog_d, ld_val_d;
  logic             ld_d;
  logic             tc_d, tc_q;
  logic             ovf_d, ovf_q;
  logic             at_top, at_bot;

  // Ripple-free T chain. A bit toggles when all lower bits are ones (up)
  // or all lower bits are zeros (down). Bit 0 always toggles.
  always_comb begin
    logic acc_u, acc_d;
    acc_u = 1'b1;
    acc_d = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      up_tog[i] = acc_u;
      dn_tog[i] = acc_d;
      acc_u     = acc_u & q[i];
      acc_d     = acc_d & ~q[i];
    end
  end

  assign at_top = &q;
  assign at_bot = ~|q;

  // Pick the per-bit action for this edge and the next flag values.
  // t and d are only routed in their own modes, so an X on them cannot
  // reach q in other modes.
  always_comb begin
    tog_d    = '0;
    ld_d     = 1'b0;
    ld_val_d = '0;
    tc_d     = 1'b0;
    ovf_d    = ovf_q;
    if (sclr) begin
      ld_d  = 1'b1;
      ovf_d = 1'b0;
    end else if (en) begin
      case (mode)
        M_TOGGLE: tog_d = t;
        M_UP: begin
          // Counting past all ones is the terminal event.
          // In saturating mode q freezes there.
          if (at_top) begin
            tc_d  = 1'b1;
            ovf_d = 1'b1;
            tog_d = SATURATE ? '0 : up_tog;
          end else begin
            tog_d = up_tog;
          end
        end
        M_DOWN: begin
          if (at_bot) begin
            tc_d  = 1'b1;
            ovf_d = 1'b1;
            tog_d = SATURATE ? '0 : dn_tog;
          end else begin
            tog_d = dn_tog;
          end
        end
        M_LOAD: begin
          ld_d     = 1'b1;
          ld_val_d = d;
        end
      endcase
    end
  end

  // One cell per bit. Each cell gets its own bit of RESET_VAL.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_bank_cell #(.RST_BIT(RESET_VAL[i])) u_cell (
      .clk      (clk),
      .clr_n    (clr_n),
      .ld_i     (ld_d),
      .ld_val_i (ld_val_d[i]),
      .tog_i    (tog_d[i]),
      .q_o      (q[i])
    );
  end

  // Flag registers update on the same edge as q.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_tff_bank_counter.sv
// Bench for tff_bank_counter. Three instances share one stimulus:
//   [0] wrapping, reset 0
//   [1] saturating, reset 0
//   [2] wrapping, reset 3
// An arithmetic reference model tracks all three.
module tb_tff_bank_counter;

  logic clk, clr_n, sclr, en;
  logic [1:0] mode;
  logic [3:0] t, d;
  logic [2:0][3:0] qv;
  logic [2:0] tcv, ovfv;

  int checks = 0;
  int errors = 0;

  logic [3:0] mq [3];
  logic       mtc [3];
  logic       movf [3];
  logic [3:0] rv [3];
  bit         sat [3];

  typedef struct {
    logic       sclr;
    logic       en;
    logic [1:0] mode;
    logic [3:0] t;
    logic [3:0] d;
    logic [3:0] eq;
    logic       etc;
    logic       eovf;
  } vec_t;
  vec_t tbl [14];

  tff_bank_counter #(.WIDTH(4), .SATURATE(1'b0), .RESET_VAL(4'h0)) u_wrap (
    .clk(clk), .clr_n(clr_n), .sclr(sclr), .en(en), .mode(mode), .t(t), .d(d),
    .q(qv[0]), .tc(tcv[0]), .ovf(ovfv[0]));
  tff_bank_counter #(.WIDTH(4), .SATURATE(1'b1), .RESET_VAL(4'h0)) u_sat (
    .clk(clk), .clr_n(clr_n), .sclr(sclr), .en(en), .mode(mode), .t(t), .d(d),
    .q(qv[1]), .tc(tcv[1]), .ovf(ovfv[1]));
  tff_bank_counter #(.WIDTH(4), .SATURATE(1'b0), .RESET_VAL(4'h3)) u_rv3 (
    .clk(clk), .clr_n(clr_n), .sclr(sclr), .en(en), .mode(mode), .t(t), .d(d),
    .q(qv[2]), .tc(tcv[2]), .ovf(ovfv[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_models(input string nm);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.q[%0d]", nm, k), 32'(qv[k]), 32'(mq[k]));
      chk($sformatf("%s.tc[%0d]", nm, k), 32'(tcv[k]), 32'(mtc[k]));
      chk($sformatf("%s.ovf[%0d]", nm, k), 32'(ovfv[k]), 32'(movf[k]));
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k] = rv[k];
      mtc[k] = 1'b0;
      movf[k] = 1'b0;
    end
  endtask

  // Next state from the behavioural rules, using plain arithmetic on q.
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (!clr_n) begin
        mq[k] = rv[k]; mtc[k] = 1'b0; movf[k] = 1'b0;
      end else if (sclr) begin
        mq[k] = 4'h0; mtc[k] = 1'b0; movf[k] = 1'b0;
      end else if (!en) begin
        mtc[k] = 1'b0;
      end else begin
        case (mode)
          2'b00: begin mq[k] = mq[k] ^ t; mtc[k] = 1'b0; end
          2'b01: begin
            if (mq[k] == 4'hF) begin
              mtc[k] = 1'b1; movf[k] = 1'b1;
              if (!sat[k]) mq[k] = 4'h0;
            end else begin
              mq[k] = mq[k] + 4'h1; mtc[k] = 1'b0;
            end
          end
          2'b10: begin
            if (mq[k] == 4'h0) begin
              mtc[k] = 1'b1; movf[k] = 1'b1;
              if (!sat[k]) mq[k] = 4'hF;
            end else begin
              mq[k] = mq[k] - 4'h1; mtc[k] = 1'b0;
            end
          end
          default: begin mq[k] = d; mtc[k] = 1'b0; end
        endcase
      end
    end
  endtask

  task automatic drive(input logic s, input logic e, input logic [1:0] m,
                       input logic [3:0] tt, input logic [3:0] dd);
    sclr = s; en = e; mode = m; t = tt; d = dd;
  endtask

  // One clock edge: advance the model, then sample 1ns after the edge.
  task automatic step(input string nm);
    @(posedge clk);
    model_edge();
    #1;
    chk_models(nm);
  endtask

  initial begin
    rv[0] = 4'h0; rv[1] = 4'h0; rv[2] = 4'h3;
    sat[0] = 1'b0; sat[1] = 1'b1; sat[2] = 1'b0;
    //            sclr en  mode   t     d      q    tc   ovf
    tbl[0]  = '{1'b0, 1'b1, 2'b00, 4'h5, 4'h0, 4'h5, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 2'b00, 4'h5, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 2'b00, 4'h5, 4'h0, 4'h5, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 2'b11, 4'h0, 4'hE, 4'hE, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 4'h1, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 2'b11, 4'h0, 4'hA, 4'hA, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 2'b11, 4'h0, 4'hA, 4'h0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 2'b10, 4'h0, 4'h0, 4'hF, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 2'b01, 4'h0, 4'h0, 4'hF, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 2'b11, 4'h0, 4'h6, 4'h6, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 2'b01, 4'h0, 4'h0, 4'h6, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 2'b00, 4'hF, 4'h0, 4'h9, 1'b0, 1'b1};

    clr_n = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 4'h0, 4'h0);

    // Async clear between edges, held across two edges, released mid-cycle.
    #7 clr_n = 1'b0;
    #1 model_reset();
    chk_models("async_clr");
    chk("async_clr.q2_rv", 32'(qv[2]), 32'h3);
    drive(1'b0, 1'b1, 2'b01, 4'h0, 4'h0);
    @(posedge clk);
    @(posedge clk);
    #1 chk_models("clr_hold");
    chk("clr_hold.q0", 32'(qv[0]), 32'h0);
    #1 clr_n = 1'b1;
    step("post_release");
    chk("post_release.q0", 32'(qv[0]), 32'h1);
    chk("post_release.q2", 32'(qv[2]), 32'h4);

    // Bring all instances to zero, then run the vector table.
    drive(1'b1, 1'b0, 2'b00, 4'h0, 4'h0);
    step("sclr0");
    foreach (tbl[i]) begin
      drive(tbl[i].sclr, tbl[i].en, tbl[i].mode, tbl[i].t, tbl[i].d);
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.q", i), 32'(qv[0]), 32'(tbl[i].eq));
      chk($sformatf("vec%0d.tc", i), 32'(tcv[0]), 32'(tbl[i].etc));
      chk($sformatf("vec%0d.ovf", i), 32'(ovfv[0]), 32'(tbl[i].eovf));
    end

    // Saturating down-count: hold at zero with tc asserted every edge.
    drive(1'b1, 1'b0, 2'b00, 4'h0, 4'h0);
    step("sat_sclr");
    drive(1'b0, 1'b1, 2'b11, 4'h0, 4'h1);
    step("sat_load");
    drive(1'b0, 1'b1, 2'b10, 4'h0, 4'h0);
    step("sat_reach");
    chk("sat_reach.q", 32'(qv[1]), 32'h0);
    chk("sat_reach.tc", 32'(tcv[1]), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step("sat_hold");
      chk($sformatf("sat_hold%0d.q", i), 32'(qv[1]), 32'h0);
      chk($sformatf("sat_hold%0d.tc", i), 32'(tcv[1]), 32'h1);
      chk($sformatf("sat_hold%0d.ovf", i), 32'(ovfv[1]), 32'h1);
    end
    drive(1'b0, 1'b1, 2'b01, 4'h0, 4'h0);
    step("sat_up");
    chk("sat_up.q", 32'(qv[1]), 32'h1);
    chk("sat_up.tc", 32'(tcv[1]), 32'h0);
    chk("sat_up.ovf", 32'(ovfv[1]), 32'h1);

    // Non-zero reset value: clear mid-count, then resume counting.
    drive(1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
    #1 clr_n = 1'b0;
    #1 model_reset();
    clr_n = 1'b1;
    drive(1'b0, 1'b1, 2'b01, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) step("rv_count");
    chk("rv_count.q2", 32'(qv[2]), 32'h7);
    #3 clr_n = 1'b0;
    #1 model_reset();
    chk("rv_pulse.q2", 32'(qv[2]), 32'h3);
    chk_models("rv_pulse");
    #1 clr_n = 1'b1;
    step("rv_resume");
    chk("rv_resume.q2", 32'(qv[2]), 32'h4);

    // Random traffic against the reference model.
    for (int n = 0; n < 500; n++) begin
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 4) != 0,
            2'($urandom), 4'($urandom), 4'($urandom));
      if ($urandom_range(0, 49) == 0) begin
        #2 clr_n = 1'b0;
        #1 model_reset();
        chk_models("rnd_clr");
        #1 clr_n = 1'b1;
      end
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
